// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter: sequential double-dabble binary-to-BCD converter with
// valid/ready handshakes on both sides and a significant-digit count.
module fib_bcd_converter #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIGITS*4-1:0]   out_bcd,
    output logic [2:0]            out_ndigits,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [DIGITS*4-1:0] acc, adj, acc_nxt;
    logic [WIDTH-1:0]    bin;
    logic [CW-1:0]       cnt;
    logic [2:0]          nd;

    // Next accumulator and its digit count, so the final shift lands directly in the outputs
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++)
            adj[4*d +: 4] = acc[4*d +: 4] >= 4'd5 ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
        acc_nxt = {adj[DIGITS*4-2:0], bin[WIDTH-1]};
        nd = 3'd1;
        for (int d = 0; d < DIGITS; d++)
            if (acc_nxt[4*d +: 4] != 4'd0) nd = 3'(d + 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            bin         <= '0;
            cnt         <= '0;
            out_bcd     <= '0;
            out_ndigits <= 3'd1;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    bin      <= in_data;
                    acc      <= '0;
                    cnt      <= CW'(WIDTH);
                    state    <= SHIFT;
                    in_ready <= 1'b0;
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    bin <= {bin[WIDTH-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        out_bcd     <= acc_nxt;
                        out_ndigits <= nd;
                        out_valid   <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb_fib_bcd_converter: directed and randomized checks of fib_bcd_converter
// against a decimal-arithmetic reference model.
module tb_fib_bcd_converter;
    localparam int WIDTH  = 17;
    localparam int DIGITS = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [WIDTH-1:0]    in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DIGITS*4-1:0] out_bcd;
    logic [2:0]          out_ndigits;
    logic                out_valid;
    logic                out_ready = 1'b0;
    int                  checks = 0;
    int                  errors = 0;

    always #5 clk = ~clk;

    fib_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bcd(out_bcd), .out_ndigits(out_ndigits),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    function automatic logic [DIGITS*4-1:0] bcd_of(int unsigned v);
        logic [DIGITS*4-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int nd_of(int unsigned v);
        int n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input int unsigned v, input int hold, input bit toggle);
        int n = 0;
        int lat = 0;
        while (!in_ready && n < 40) begin
            step;
            n++;
        end
        check("ready_before_accept", 32'(in_ready), 1);
        in_data  = WIDTH'(v);
        in_valid = 1'b1;
        step;
        check("ready_drops", 32'(in_ready), 0);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (toggle) begin
                in_data  = WIDTH'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            step;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, WIDTH);
        check("bcd", 32'(out_bcd), 32'(bcd_of(v)));
        check("ndigits", 32'(out_ndigits), nd_of(v));
        for (int i = 0; i < hold; i++) begin
            step;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_bcd", 32'(out_bcd), 32'(bcd_of(v)));
            check("hold_nd", 32'(out_ndigits), nd_of(v));
            check("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 0);
        check("release_ready", 32'(in_ready), 1);
    endtask

    initial begin
        int fib[25];
        int q[$];
        int idx, outs, cyc, last_acc;
        bit rdy;

        repeat (2) step;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_bcd", 32'(out_bcd), 0);
        check("rst_nd", 32'(out_ndigits), 1);
        reset = 1'b0;
        step;
        check("post_rst_ready", 32'(in_ready), 1);

        convert(0, 0, 1'b0);
        convert(987, 1, 1'b0);
        convert(131071, 0, 1'b0);
        convert(46368, 10, 1'b0);

        // Abort a conversion mid-shift; the result must never surface
        in_data  = WIDTH'(121393);
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (7) step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_ready", 32'(in_ready), 1);
        for (int i = 0; i < 25; i++) begin
            step;
            check("abort_quiet", 32'(out_valid), 0);
        end
        convert(10946, 0, 1'b0);

        for (int i = 0; i < 8; i++)
            convert($urandom_range(0, 2**WIDTH - 1), $urandom_range(0, 3), 1'b1);

        fib[0] = 1;
        fib[1] = 1;
        for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];
        idx = 0; outs = 0; cyc = 0; last_acc = -1;
        out_ready = 1'b1;
        in_data   = WIDTH'(fib[0]);
        in_valid  = 1'b1;
        while (outs < 25 && cyc < 25*19 + 100) begin
            rdy = in_ready;
            if (out_valid) begin
                if (q.size() == 0) check("fib_unexpected", 32'(out_bcd), 32'hffffffff);
                else check("fib_bcd", 32'(out_bcd), 32'(bcd_of(q.pop_front())));
                outs++;
            end
            step;
            cyc++;
            if (rdy && in_valid) begin
                q.push_back(fib[idx]);
                if (last_acc >= 0) check("fib_period", cyc - last_acc, 19);
                last_acc = cyc;
                idx++;
                if (idx < 25) in_data = WIDTH'(fib[idx]);
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("fib_count", outs, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
